// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the 640x480@60 Hz VGA timing and its users.
package vga_pkg;

    localparam int CNT_W     = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START  = H_VISIBLE + H_FP;
    localparam int HS_END    = HS_START + H_SYNC - 1;
    localparam int VS_START  = V_VISIBLE + V_FP;
    localparam int VS_END    = VS_START + V_SYNC - 1;

    localparam int RGB_W     = 12;
    localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// Column/line counter pair with a configurable reset position.
module raster_counter
    import vga_pkg::*;
#(
    parameter int H_TOT  = 800,
    parameter int V_TOT  = 525,
    parameter int H_INIT = 0,
    parameter int V_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_RESET = CNT_W'(H_INIT);
    localparam logic [CNT_W-1:0] V_RESET = CNT_W'(V_INIT);

    // Column advances every clock; the line advances on each column wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= H_RESET;
            v_cnt <= V_RESET;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing, lookahead counters, blanking and registered VGA pins.
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int LOOKAHEAD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [vga_pkg::RGB_W-1:0] pixel_in,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic [vga_pkg::CNT_W-1:0] ah_cnt,
    output logic [vga_pkg::CNT_W-1:0] av_cnt,
    output logic                      valid,
    output logic                      line_start,
    output logic                      frame_start,
    output logic [15:0]               frame_cnt,
    output logic                      hsync,
    output logic                      vsync,
    output logic [vga_pkg::RGB_W-1:0] vga_rgb
);
    import vga_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOT - 1);

    logic                 hsync_p1;
    logic                 vsync_p1;
    logic [RGB_W-1:0]     vga_rgb_p1;
    logic                 end_of_frame;

    // Raster position of the pixel currently being emitted.
    raster_counter #(
        .H_TOT  (H_TOT),
        .V_TOT  (V_TOT),
        .H_INIT (0),
        .V_INIT (0)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt)
    );

    // Separate counter pair started LOOKAHEAD columns ahead, so the lead
    // survives line and frame wraps without an adder/modulo on the path.
    raster_counter #(
        .H_TOT  (H_TOT),
        .V_TOT  (V_TOT),
        .H_INIT (LOOKAHEAD),
        .V_INIT (0)
    ) u_look (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (ah_cnt),
        .v_cnt (av_cnt)
    );

    assign valid        = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign line_start   = (h_cnt == '0);
    assign frame_start  = line_start && (v_cnt == '0);
    assign end_of_frame = (h_cnt == H_LAST_C) && (v_cnt == V_LAST_C);

    // ---- stage p0 -> p1: registered pins, all aligned one cycle behind h_cnt/v_cnt
    // Sync pulses and blanked colour registered together so the pins stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_p1   <= 1'b1;
            vsync_p1   <= 1'b1;
            vga_rgb_p1 <= RGB_BLACK;
        end else begin
            hsync_p1   <= ~((h_cnt >= HS_START_C) && (h_cnt <= HS_END_C));
            vsync_p1   <= ~((v_cnt >= VS_START_C) && (v_cnt <= VS_END_C));
            vga_rgb_p1 <= valid ? pixel_in : RGB_BLACK;
        end
    end

    // Completed-frame count, bumped on the edge where both counters wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (end_of_frame) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign hsync   = hsync_p1;
    assign vsync   = vsync_p1;
    assign vga_rgb = vga_rgb_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen (default 640x480 timing, LOOKAHEAD=2).
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = 12'hfff;
    logic [9:0]  h_cnt, v_cnt, ah_cnt, av_cnt;
    logic        valid, line_start, frame_start, hsync, vsync;
    logic [15:0] frame_cnt;
    logic [11:0] vga_rgb;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [9:0]  jh, jv, jah, jav;
    logic [15:0] jfc;

    typedef struct {
        int cyc;
        int h;  int v;  int ah; int av;
        int vld; int ls; int fs;
        int hs; int vs; int rgb;
    } vec_t;

    vec_t tbl[$];

    vga_timing_gen dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .ah_cnt      (ah_cnt),
        .av_cnt      (av_cnt),
        .valid       (valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_rgb     (vga_rgb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Move both counter pairs to a raster position (lookahead kept consistent).
    task jump(input int h, input int v);
        jh  = 10'(h);
        jv  = 10'(v);
        jah = 10'((h + 2) % 800);
        jav = 10'(((h + 2) >= 800) ? (v + 1) % 525 : v);
        force dut.u_main.h_cnt = jh;
        force dut.u_main.v_cnt = jv;
        force dut.u_look.h_cnt = jah;
        force dut.u_look.v_cnt = jav;
        #1;
        release dut.u_main.h_cnt;
        release dut.u_main.v_cnt;
        release dut.u_look.h_cnt;
        release dut.u_look.v_cnt;
    endtask

    task automatic wait_pos(input int h, input int v, input int budget);
        int n = 0;
        while (!(int'(h_cnt) == h && int'(v_cnt) == v) && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("reach_h%0d_v%0d", h, v), int'(int'(h_cnt) == h && int'(v_cnt) == v), 1);
    endtask

    task automatic chk_pos(input string tag, input int h, input int v, input int ah, input int av);
        chk({tag, "_h"},  int'(h_cnt),  h);
        chk({tag, "_v"},  int'(v_cnt),  v);
        chk({tag, "_ah"}, int'(ah_cnt), ah);
        chk({tag, "_av"}, int'(av_cnt), av);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached, expected normal end");
        $fatal(1, "timeout");
    end

    initial begin
        int lo, first_h, first_v, blank_err;

        tbl.push_back(vec_t'{0,    0,   0,  2,   0, 1, 1, 1, 1, 1, 'h000});
        tbl.push_back(vec_t'{1,    1,   0,  3,   0, 1, 0, 0, 1, 1, 'hfff});
        tbl.push_back(vec_t'{639,  639, 0,  641, 0, 1, 0, 0, 1, 1, 'hfff});
        tbl.push_back(vec_t'{640,  640, 0,  642, 0, 0, 0, 0, 1, 1, 'hfff});
        tbl.push_back(vec_t'{641,  641, 0,  643, 0, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{656,  656, 0,  658, 0, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{657,  657, 0,  659, 0, 0, 0, 0, 0, 1, 'h000});
        tbl.push_back(vec_t'{752,  752, 0,  754, 0, 0, 0, 0, 0, 1, 'h000});
        tbl.push_back(vec_t'{753,  753, 0,  755, 0, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{797,  797, 0,  799, 0, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{798,  798, 0,  0,   1, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{799,  799, 0,  1,   1, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{800,  0,   1,  2,   1, 1, 1, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{801,  1,   1,  3,   1, 1, 0, 0, 1, 1, 'hfff});
        tbl.push_back(vec_t'{8797, 797, 10, 799, 10, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{8798, 798, 10, 0,   11, 0, 0, 0, 1, 1, 'h000});
        tbl.push_back(vec_t'{8800, 0,   11, 2,   11, 1, 1, 0, 1, 1, 'h000});

        // Reset held: counters parked, pins idle, valid/frame_start combinational.
        rst = 1'b1;
        tick();
        tick();
        chk_pos("rst", 0, 0, 2, 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_rgb", int'(vga_rgb), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_valid", int'(valid), 1);
        chk("rst_frame_start", int'(frame_start), 1);

        rst = 1'b0;
        cyc = 0;

        foreach (tbl[i]) begin
            string t;
            while (cyc < tbl[i].cyc) tick();
            t = $sformatf("c%0d", tbl[i].cyc);
            chk_pos(t, tbl[i].h, tbl[i].v, tbl[i].ah, tbl[i].av);
            chk({t, "_valid"},  int'(valid),       tbl[i].vld);
            chk({t, "_lstart"}, int'(line_start),  tbl[i].ls);
            chk({t, "_fstart"}, int'(frame_start), tbl[i].fs);
            chk({t, "_hsync"},  int'(hsync),       tbl[i].hs);
            chk({t, "_vsync"},  int'(vsync),       tbl[i].vs);
            chk({t, "_rgb"},    int'(vga_rgb),     tbl[i].rgb);
            chk({t, "_fcnt"},   int'(frame_cnt),   0);
        end

        // One full line (h 0..799 of line 11): hsync low length and start.
        lo = 0; first_h = -1;
        for (int k = 0; k < 800; k++) begin
            if (!hsync) begin
                if (lo == 0) first_h = int'(h_cnt);
                lo++;
            end
            tick();
        end
        chk("hsync_low_len", lo, 96);
        chk("hsync_first_low_h", first_h, 657);

        // Vertical blanking and vsync window, entered near the end of line 489.
        jump(790, 489);
        lo = 0; first_h = -1; first_v = -1; blank_err = 0;
        for (int k = 0; k < 4000; k++) begin
            if (!vsync) begin
                if (lo == 0) begin
                    first_h = int'(h_cnt);
                    first_v = int'(v_cnt);
                end
                lo++;
            end
            if (vga_rgb != 12'h000 || valid) blank_err++;
            tick();
        end
        chk("vsync_low_len", lo, 1600);
        chk("vsync_first_low_h", first_h, 1);
        chk("vsync_first_low_v", first_v, 490);
        chk("vblank_rgb_nonzero", blank_err, 0);

        // Natural run to the end of frame: lookahead wrap and frame_cnt bump.
        wait_pos(797, 524, 30000);
        chk_pos("eof797", 797, 524, 799, 524);
        tick();
        chk_pos("eof798", 798, 524, 0, 0);
        tick();
        chk_pos("eof799", 799, 524, 1, 0);
        chk("eof799_fcnt", int'(frame_cnt), 0);
        tick();
        chk_pos("sof", 0, 0, 2, 0);
        chk("sof_fstart", int'(frame_start), 1);
        chk("sof_fcnt", int'(frame_cnt), 1);

        // Mid-frame reset at (300,200), held 3 cycles.
        jump(290, 200);
        for (int k = 0; k < 10; k++) tick();
        chk_pos("pre_rst", 300, 200, 302, 200);
        chk("pre_rst_rgb", int'(vga_rgb), 'hfff);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_pos($sformatf("mrst%0d", k), 0, 0, 2, 0);
            chk($sformatf("mrst%0d_hsync", k), int'(hsync), 1);
            chk($sformatf("mrst%0d_vsync", k), int'(vsync), 1);
            chk($sformatf("mrst%0d_rgb", k), int'(vga_rgb), 0);
            chk($sformatf("mrst%0d_fcnt", k), int'(frame_cnt), 0);
        end
        rst = 1'b0;
        chk("resume_h0", int'(h_cnt), 0);
        tick();
        chk("resume_h1", int'(h_cnt), 1);
        tick();
        chk("resume_h2", int'(h_cnt), 2);
        chk("resume_ah4", int'(ah_cnt), 4);

        // frame_cnt wrap: preload 65535 just before a frame end.
        jump(790, 524);
        jfc = 16'hffff;
        force dut.frame_cnt = jfc;
        #1;
        release dut.frame_cnt;
        wait_pos(799, 524, 20);
        chk("wrap_pre_fcnt", int'(frame_cnt), 65535);
        tick();
        chk("wrap_fcnt", int'(frame_cnt), 0);
        chk_pos("wrap", 0, 0, 2, 0);
        chk("wrap_fstart", int'(frame_start), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
